// File: rtl/img_mem_read.sv
// Raster-order reader for the image RAM: issues reads with credit-based flow control
// and streams the returned pixels with row/col/last tags through a small output FIFO.
module img_mem_read #(
    parameter int unsigned IMG_W  = 28,
    parameter int unsigned IMG_H  = 28,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned FIFO_D = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] addr0,
    output logic              rden,
    input  logic [DATA_W-1:0] q,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [4:0]        pix_row,
    output logic [4:0]        pix_col,
    output logic              pix_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

    localparam int unsigned       NPIX    = IMG_W * IMG_H;
    localparam int unsigned       PW      = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam int unsigned       CW      = $clog2(FIFO_D + 1);
    localparam int unsigned       SW      = CW + 1;
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(NPIX - 1);
    localparam logic [PW-1:0]     PTR_MAX = PW'(FIFO_D - 1);
    localparam logic [SW-1:0]     DEPTH   = SW'(FIFO_D);
    localparam logic [4:0]        COL_MAX = 5'(IMG_W - 1);
    localparam logic [4:0]        ROW_MAX = 5'(IMG_H - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT:0]   vld_ext;
    logic [4:0]        row_q, col_q;
    logic [PW-1:0]     wr_q, rd_q;
    logic [CW-1:0]     occ_q, occ_d;
    logic [CW-1:0]     infl;
    logic              push, pop, tag_last;

    logic [DATA_W-1:0] mem_data [FIFO_D];
    logic [4:0]        mem_row  [FIFO_D];
    logic [4:0]        mem_col  [FIFO_D];
    logic              mem_last [FIFO_D];

    assign vld_ext   = {vld_q, rden};
    assign infl      = CW'($countones(vld_q));
    assign push      = vld_q[RD_LAT-1];
    assign pix_valid = (occ_q != '0);
    assign pop       = pix_valid & pix_ready;
    assign tag_last  = (row_q == ROW_MAX) && (col_q == COL_MAX);

    assign pix_data  = pix_valid ? mem_data[rd_q] : '0;
    assign pix_row   = pix_valid ? mem_row[rd_q]  : '0;
    assign pix_col   = pix_valid ? mem_col[rd_q]  : '0;
    assign pix_last  = pix_valid ? mem_last[rd_q] : 1'b0;
    assign addr0     = addr_q;
    assign busy      = (state_q == ISSUE) || (state_q == DRAIN);
    assign done      = (state_q == FINISH);

    // A read may issue if the slot it needs is free counting this cycle's pop.
    always_comb begin
        state_d = state_q;
        rden    = 1'b0;
        case (state_q)
            IDLE:   if (start) state_d = ISSUE;
            ISSUE: begin
                rden = (SW'(occ_q) + SW'(infl)) < (DEPTH + SW'(pop));
                if (rden && (addr_q == LAST_A)) state_d = DRAIN;
            end
            DRAIN:  if (pop && pix_last) state_d = FINISH;
            FINISH: state_d = IDLE;
        endcase
    end

    always_comb begin
        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            vld_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_ext[RD_LAT-1:0];
            occ_q   <= occ_d;
            if (state_q == IDLE && start) begin
                addr_q <= '0;
                row_q  <= '0;
                col_q  <= '0;
            end else begin
                if (rden && addr_q != LAST_A) addr_q <= addr_q + ADDR_W'(1);
                if (push) begin
                    if (col_q == COL_MAX) begin
                        col_q <= '0;
                        row_q <= row_q + 5'd1;
                    end else begin
                        col_q <= col_q + 5'd1;
                    end
                end
            end
            if (push) wr_q <= (wr_q == PTR_MAX) ? '0 : wr_q + PW'(1);
            if (pop)  rd_q <= (rd_q == PTR_MAX) ? '0 : rd_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_q] <= q;
            mem_row[wr_q]  <= row_q;
            mem_col[wr_q]  <= col_q;
            mem_last[wr_q] <= tag_last;
        end
    end

endmodule

// File: tb/tb_img_mem_read.sv
// Directed bench for img_mem_read: cycle-exact full-rate frames, backpressure,
// random ready, start-while-busy and mid-frame reset against a 1-cycle RAM model.
module tb_img_mem_read;

    logic       clk = 1'b0;
    logic       reset, start, pix_ready;
    logic [9:0] addr0;
    logic       rden;
    logic [7:0] q;
    logic [7:0] pix_data;
    logic       pix_valid;
    logic [4:0] pix_row, pix_col;
    logic       pix_last, busy, done;
    logic [7:0] seed;
    int         n_assert = 0;
    int         n_fail   = 0;

    img_mem_read #(.IMG_W(28), .IMG_H(28), .DATA_W(8), .ADDR_W(10), .RD_LAT(1), .FIFO_D(4)) dut (
        .clk(clk), .reset(reset), .start(start), .addr0(addr0), .rden(rden), .q(q),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_row(pix_row), .pix_col(pix_col), .pix_last(pix_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM whose content is address plus a frame-specific seed.
    always @(posedge clk) if (rden) q <= addr0[7:0] + seed;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic st, input logic rst);
        @(negedge clk);
        pix_ready = rdy;
        start     = st;
        reset     = rst;
        #1;
    endtask

    task automatic full_frame();
        logic [7:0] ed;
        drive(1'b1, 1'b1, 1'b0);
        chk("ff_idle_busy", busy, 0);
        for (int c = 1; c <= 787; c++) begin
            drive(1'b1, 1'b0, 1'b0);
            if (c == 1) begin
                chk("ff_c1_rden", rden, 1);
                chk("ff_c1_addr", addr0, 0);
            end
            chk("ff_valid", pix_valid, (c >= 3 && c <= 786));
            if (c >= 3 && c <= 786) begin
                ed = 8'(c - 3) + seed;
                chk("ff_data", pix_data, ed);
                chk("ff_row", pix_row, (c - 3) / 28);
                chk("ff_col", pix_col, (c - 3) % 28);
                chk("ff_last", pix_last, (c == 786));
            end
            chk("ff_done", done, (c == 787));
            chk("ff_busy", busy, (c <= 786));
        end
    endtask

    // mode 0: ready low cycles 10-29; 1: random 30% ready; 2: extra starts at 100/500; 3: ready high
    task automatic gen_frame(input int mode);
        int         k = 0, dn = 0, c = 1, tail = 0;
        logic       stall = 1'b0, rdy, st;
        logic [7:0] pd, ed;
        logic [4:0] pr, pc;
        drive(1'b1, 1'b1, 1'b0);
        while (c < 6000 && tail < 3) begin
            rdy = 1'b1;
            if (mode == 0) rdy = !(c >= 10 && c <= 29);
            if (mode == 1) rdy = ($urandom_range(0, 99) < 30);
            st = (mode == 2) && (c == 100 || c == 500);
            drive(rdy, st, 1'b0);
            if (stall) begin
                chk("stall_valid", pix_valid, 1);
                chk("stall_data", pix_data, pd);
                chk("stall_row", pix_row, pr);
                chk("stall_col", pix_col, pc);
            end
            if (mode == 0 && c == 20) begin
                chk("bp_rden_full", rden, 0);
                chk("bp_valid_full", pix_valid, 1);
            end
            if (mode == 0 && c == 30) chk("bp_rden_resume", rden, 1);
            if (pix_valid && pix_ready) begin
                ed = 8'(k) + seed;
                chk("px_data", pix_data, ed);
                chk("px_row", pix_row, k / 28);
                chk("px_col", pix_col, k % 28);
                chk("px_last", pix_last, (k == 783));
                k++;
            end
            if (done) dn++;
            stall = pix_valid && !pix_ready;
            pd = pix_data;
            pr = pix_row;
            pc = pix_col;
            if (k == 784) tail++;
            c++;
        end
        chk("frame_in_time", (c < 6000), 1);
        chk("frame_count", k, 784);
        chk("done_count", dn, 1);
        chk("end_idle_valid", pix_valid, 0);
        chk("end_idle_busy", busy, 0);
    endtask

    initial begin
        seed = 8'h00;
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        chk("rst_addr", addr0, 0);
        chk("rst_rden", rden, 0);
        chk("rst_valid", pix_valid, 0);
        chk("rst_data", pix_data, 0);
        chk("rst_row", pix_row, 0);
        chk("rst_col", pix_col, 0);
        chk("rst_last", pix_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        full_frame();
        full_frame();
        gen_frame(0);
        gen_frame(1);
        gen_frame(2);

        drive(1'b1, 1'b1, 1'b0);
        for (int c = 1; c < 400; c++) drive(1'b1, 1'b0, 1'b0);
        chk("pre_rst_busy", busy, 1);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        chk("mid_rst_valid", pix_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_addr", addr0, 0);
        chk("mid_rst_rden", rden, 0);
        chk("mid_rst_done", done, 0);
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0, 1'b0);
            chk("post_rst_valid", pix_valid, 0);
        end
        seed = 8'h55;
        gen_frame(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/img_mem_read.md
# img_mem_read

Read-side addresser for the 28x28 input image memory. On `start` it walks all 784 pixel addresses in raster order against a synchronous-read RAM. It buffers the returned words in a small FIFO so that downstream backpressure never loses data, and streams pixels with row/column tags and a last flag over a valid/ready interface to the first layer. It is the consumer counterpart of the image-memory write counter.

## Interface
- `IMG_W`, default 28: pixels per row.
- `IMG_H`, default 28: rows per image.
- `DATA_W`, default 8: pixel width.
- `ADDR_W`, default 10: memory address width; must satisfy 2^ADDR_W ≥ IMG_W*IMG_H.
- `RD_LAT`, default 1: RAM read latency in cycles, from `rden` to `q` valid.
- `FIFO_D`, default 4: output buffer depth; must be ≥ RD_LAT+2.

Ports:
- `clk` in, 1: single clock, all logic is rising-edge.
- `reset` in, 1: synchronous, active-high.
- `start` in, 1: one-cycle request to read one full image.
- `addr0` out, ADDR_W: RAM read address.
- `rden` out, 1: RAM read enable.
- `q` in, DATA_W: RAM read data, valid RD_LAT cycles after `rden`.
- `pix_data` out, DATA_W: pixel at the FIFO head.
- `pix_valid` out, 1: `pix_data` and its tags are valid.
- `pix_ready` in, 1: downstream accepts the pixel.
- `pix_row` out, 5: row index of the head pixel.
- `pix_col` out, 5: column index of the head pixel.
- `pix_last` out, 1: head pixel is the final pixel (row IMG_H-1, col IMG_W-1).
- `busy` out, 1: frame in progress.
- `done` out, 1: one-cycle pulse after the last pixel is accepted.

## Operation
- **States:** IDLE, ISSUE, DRAIN, FINISH.
  - IDLE → ISSUE on `start`.
  - ISSUE → DRAIN after the read of address IMG_W*IMG_H-1 is issued.
  - DRAIN → FINISH when the last pixel is accepted (`pix_valid & pix_ready & pix_last`).
  - FINISH → IDLE unconditionally after one cycle.
- **Accept:** a pixel is accepted in a cycle where `pix_valid & pix_ready` are both high; that is a pop.
- **Issue rule:** in ISSUE, `rden`=1 iff `occ + inflight − pop < FIFO_D`.
  - `occ` is FIFO occupancy; `inflight` is the count of reads issued but not yet returned (≤ RD_LAT).
  - The FIFO can never overflow. With `pix_ready` held high, one read issues per cycle.
- **Address counter:** `addr0` increments by 1 on each issued read, from 0 to IMG_W*IMG_H-1 (783). After the final read it holds its value; it never wraps.
- **Valid pipeline:** an RD_LAT-deep shift register of `rden` marks returning data. The returning `q` is pushed into the FIFO on that edge, tagged with its row, column and last flag.
  - Row/col tags come from a separate counter pair: col wraps IMG_W-1 → 0 and increments row.
- **Head outputs:** `pix_valid` = FIFO not empty. `pix_data`, `pix_row`, `pix_col` and `pix_last` show the head entry. They are held stable while `pix_valid & !pix_ready`.
- **Status:** `busy`=1 in ISSUE and DRAIN. `done`=1 only in FINISH.
- **`start` when not IDLE:** ignored; there is no queueing.
- **Reset (any state, including mid-frame):** next cycle is IDLE; the FIFO is emptied and the in-flight pipeline is cleared. Returning RAM data from reads issued before reset is discarded.
- **Reset values:** `addr0`=0, `rden`=0, `pix_valid`=0, `pix_data`=0, `pix_row`=0, `pix_col`=0, `pix_last`=0, `busy`=0, `done`=0.

## Timing
Cycle numbering assumes `start` is high in cycle 0 and RD_LAT=1.
- **Cycle 1:** ISSUE, `rden`=1, `addr0`=0.
- **Cycle 2:** `q` holds pixel 0, which is pushed at the end of the cycle.
- **Cycle 3:** first `pix_valid`=1, `pix_row`=0, `pix_col`=0.
- **Latency:** 3 cycles from `start` to the first valid pixel.
- **Full-rate frame, `pix_ready` held 1:**
  - Pixel k appears in cycle 3+k.
  - The last pixel, row 27 col 27, is in cycle 786.
  - `done` pulses in cycle 787; `busy` falls in cycle 787.
  - IDLE in cycle 788; a new `start` is accepted from cycle 788.
- **Pixel rate:** one pixel per cycle while `pix_ready`=1, with no bubbles after the first pixel.
- **Backpressure:** after `pix_ready` falls, `rden` deasserts once `occ + inflight` reaches FIFO_D. Issue resumes in the same cycle that a pop frees a slot.
- **Simultaneous push and pop:** occupancy is unchanged; both occur.
- **Empty FIFO:** a push writes the entry and `pix_valid` rises the following cycle. There is no fall-through.

## Test plan
- **Full rate:** RAM preloaded with mem[a]=a[7:0], `pix_ready`=1, `start` at cycle 0 → 784 pixels in cycles 3..786 with `pix_data`=k[7:0] in cycle 3+k; `pix_last` only on (27,27); `done` pulse in cycle 787.
- **Backpressure:** `pix_ready` low for cycles 10–29 → `rden` low while the FIFO is full (occ=4); no pixel lost or duplicated; the accepted sequence is still 0..783 and the row/col tags match k/28, k%28.
- **Random ready:** `pix_ready` random at 30% duty → the full frame is received in order; `pix_data` is stable while stalled; `done` pulses exactly once.
- **Reset mid-frame:** `reset` asserted at cycle 400 → next cycle has `pix_valid`=0, `busy`=0 and `addr0`=0. A new `start` then yields pixel 0 first, with no stale data.
- **`start` while busy:** `start` pulsed at cycles 100 and 500 → ignored; exactly 784 pixels and one `done`.
- **Back-to-back frames:** `start` in cycle 788 after the first frame → the second frame begins `rden` with `addr0`=0 in cycle 789, and its first `pix_valid` is in cycle 791.
